// File: rtl/lsq_data_memory.sv
// lsq_data_memory: single-outstanding load/store responder that owns the
// local byte-addressed data RAM and returns tagged responses to the LSQ.
module lsq_data_memory #(
    parameter int MEM_BYTES = 1024,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [5:0]  req_rob_index,
    input  logic [5:0]  req_rd_tag,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_is_store,
    output logic [5:0]  resp_rob_index,
    output logic [5:0]  resp_rd_tag,
    output logic [31:0] resp_value,
    output logic        resp_error
);

    localparam int AW = $clog2(MEM_BYTES);
    localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t state, state_next;
    logic [3:0]    lat_cnt;
    logic [7:0]    mem [MEM_BYTES];

    logic          accept;
    logic [AW-1:0] req_idx;
    logic          req_err;
    logic          unused_addr_bits;

    logic          lat_is_store;
    logic [2:0]    lat_func3;
    logic [AW-1:0] lat_idx;
    logic [5:0]    lat_rob;
    logic [5:0]    lat_tag;
    logic          lat_err;
    logic [31:0]   load_value;

    assign req_ready        = (state == IDLE);
    assign resp_valid       = (state == RESP);
    assign accept           = req_valid && (state == IDLE);
    assign req_idx          = req_addr[AW-1:0];
    assign unused_addr_bits = ^req_addr[31:AW];

    // Flag illegal func3 encodings and misaligned half/word accesses
    always_comb begin
        req_err = 1'b0;
        if (req_is_store) begin
            if (req_func3 != 3'b000 && req_func3 != 3'b001 && req_func3 != 3'b010)
                req_err = 1'b1;
        end else begin
            if (req_func3 == 3'b011 || req_func3 == 3'b110 || req_func3 == 3'b111)
                req_err = 1'b1;
        end
        if (req_func3[1:0] == 2'b01 && req_addr[0])
            req_err = 1'b1;
        if (req_func3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
            req_err = 1'b1;
    end

    // State register; reset abandons any in-flight request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic: accept, wait out the latency, hold until consumed
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req_valid) state_next = BUSY;
            BUSY: if (lat_cnt == LAT_LAST) state_next = RESP;
            RESP: if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latency counter restarts on every accept and advances while busy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            lat_cnt <= 4'd0;
        else if (accept)
            lat_cnt <= 4'd0;
        else if (state == BUSY)
            lat_cnt <= lat_cnt + 4'd1;
    end

    // Capture the request fields on the accept edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_is_store <= 1'b0;
            lat_func3    <= 3'd0;
            lat_idx      <= '0;
            lat_rob      <= 6'd0;
            lat_tag      <= 6'd0;
            lat_err      <= 1'b0;
        end else if (accept) begin
            lat_is_store <= req_is_store;
            lat_func3    <= req_func3;
            lat_idx      <= req_idx;
            lat_rob      <= req_rob_index;
            lat_tag      <= req_rd_tag;
            lat_err      <= req_err;
        end
    end

    // Stores commit on the accept edge so any later load sees them
    always_ff @(posedge clk) begin
        if (accept && req_is_store && !req_err) begin
            case (req_func3[1:0])
                2'b00: mem[req_idx] <= req_wdata[7:0];
                2'b01: begin
                    mem[req_idx]          <= req_wdata[7:0];
                    mem[req_idx + AW'(1)] <= req_wdata[15:8];
                end
                2'b10: begin
                    mem[req_idx]          <= req_wdata[7:0];
                    mem[req_idx + AW'(1)] <= req_wdata[15:8];
                    mem[req_idx + AW'(2)] <= req_wdata[23:16];
                    mem[req_idx + AW'(3)] <= req_wdata[31:24];
                end
                default: ;
            endcase
        end
    end

    // Assemble the little-endian load result with sign or zero extension
    always_comb begin
        load_value = 32'd0;
        case (lat_func3)
            3'b000: load_value = {{24{mem[lat_idx][7]}}, mem[lat_idx]};
            3'b001: load_value = {{16{mem[lat_idx + AW'(1)][7]}}, mem[lat_idx + AW'(1)], mem[lat_idx]};
            3'b010: load_value = {mem[lat_idx + AW'(3)], mem[lat_idx + AW'(2)],
                                  mem[lat_idx + AW'(1)], mem[lat_idx]};
            3'b100: load_value = {24'd0, mem[lat_idx]};
            3'b101: load_value = {16'd0, mem[lat_idx + AW'(1)], mem[lat_idx]};
            default: load_value = 32'd0;
        endcase
    end

    // Response registers load when entering RESP and clear once consumed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_is_store  <= 1'b0;
            resp_rob_index <= 6'd0;
            resp_rd_tag    <= 6'd0;
            resp_value     <= 32'd0;
            resp_error     <= 1'b0;
        end else if (state == BUSY && lat_cnt == LAT_LAST) begin
            resp_is_store  <= lat_is_store;
            resp_rob_index <= lat_rob;
            resp_rd_tag    <= lat_is_store ? 6'd0 : lat_tag;
            resp_value     <= (lat_is_store || lat_err) ? 32'd0 : load_value;
            resp_error     <= lat_err;
        end else if (state == RESP && resp_ready) begin
            resp_is_store  <= 1'b0;
            resp_rob_index <= 6'd0;
            resp_rd_tag    <= 6'd0;
            resp_value     <= 32'd0;
            resp_error     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lsq_data_memory.sv
// tb_lsq_data_memory: directed checks of the LSQ data memory responder.
module tb_lsq_data_memory;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [5:0]  req_rob_index;
    logic [5:0]  req_rd_tag;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_is_store;
    logic [5:0]  resp_rob_index;
    logic [5:0]  resp_rd_tag;
    logic [31:0] resp_value;
    logic        resp_error;

    int total = 0;
    int bad   = 0;

    lsq_data_memory #(.MEM_BYTES(1024), .LATENCY(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_func3(req_func3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rob_index(req_rob_index), .req_rd_tag(req_rd_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_is_store(resp_is_store), .resp_rob_index(resp_rob_index),
        .resp_rd_tag(resp_rd_tag), .resp_value(resp_value),
        .resp_error(resp_error)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Present one request at a negedge and drop it right after the accept edge
    task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [5:0] rob, input logic [5:0] tag);
        @(negedge clk);
        req_is_store  = st;
        req_func3     = f3;
        req_addr      = addr;
        req_wdata     = wdata;
        req_rob_index = rob;
        req_rd_tag    = tag;
        req_valid     = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Count edges after accept until resp_valid, bounded
    task automatic waitResp(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!resp_valid && n < 20);
    endtask

    task automatic consumeResp();
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    // Full transaction with the expected response computed by hand
    task automatic runTxn(input string name, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [5:0] rob, input logic [5:0] tag,
                          input logic [31:0] exp_val, input logic exp_err);
        int n;
        applyStimulus(st, f3, addr, wdata, rob, tag);
        waitResp(n);
        checkOutput({name, "_latency"}, 32'(n), 32'd2);
        checkOutput({name, "_value"}, resp_value, exp_val);
        checkOutput({name, "_error"}, {31'd0, resp_error}, {31'd0, exp_err});
        checkOutput({name, "_rob"}, {26'd0, resp_rob_index}, {26'd0, rob});
        checkOutput({name, "_tag"}, {26'd0, resp_rd_tag}, st ? 32'd0 : {26'd0, tag});
        checkOutput({name, "_is_store"}, {31'd0, resp_is_store}, {31'd0, st});
        consumeResp();
        checkOutput({name, "_ready_after"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int n;
        int seen;
        reset_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_is_store = 1'b0; req_func3 = 3'd0; req_addr = 32'd0;
        req_wdata = 32'd0; req_rob_index = 6'd0; req_rd_tag = 6'd0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("reset_resp_value", resp_value, 32'd0);
        checkOutput("reset_resp_tag", {26'd0, resp_rd_tag}, 32'd0);

        // Reset while busy: no response may ever appear for the aborted load
        applyStimulus(1'b0, 3'b010, 32'h20, 32'd0, 6'd3, 6'd12);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_resp_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checkOutput("midreset_req_ready", {31'd0, req_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen = 1;
        end
        checkOutput("midreset_no_resp", 32'(seen), 32'd0);

        // Word store then word load
        runTxn("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 6'd4, 6'd7, 32'd0, 1'b0);
        runTxn("lw_10", 1'b0, 3'b010, 32'h10, 32'd0, 6'd5, 6'd33, 32'hDEADBEEF, 1'b0);

        // Sub-word loads with sign and zero extension
        runTxn("lb_13", 1'b0, 3'b000, 32'h13, 32'd0, 6'd6, 6'd1, 32'hFFFFFFDE, 1'b0);
        runTxn("lbu_13", 1'b0, 3'b100, 32'h13, 32'd0, 6'd7, 6'd2, 32'h000000DE, 1'b0);
        runTxn("lh_10", 1'b0, 3'b001, 32'h10, 32'd0, 6'd8, 6'd3, 32'hFFFFBEEF, 1'b0);
        runTxn("lhu_12", 1'b0, 3'b101, 32'h12, 32'd0, 6'd9, 6'd4, 32'h0000DEAD, 1'b0);

        // Byte store touches one byte only
        runTxn("sb_11", 1'b1, 3'b000, 32'h11, 32'h12345677, 6'd10, 6'd20, 32'd0, 1'b0);
        runTxn("lw_10_after_sb", 1'b0, 3'b010, 32'h10, 32'd0, 6'd11, 6'd21, 32'hDEAD77EF, 1'b0);

        // Misaligned and illegal encodings raise error and leave RAM untouched
        runTxn("lw_12_misal", 1'b0, 3'b010, 32'h12, 32'd0, 6'd12, 6'd22, 32'd0, 1'b1);
        runTxn("sh_11_misal", 1'b1, 3'b001, 32'h11, 32'hFFFFFFFF, 6'd13, 6'd23, 32'd0, 1'b1);
        runTxn("st_f3_011", 1'b1, 3'b011, 32'h10, 32'h00000000, 6'd14, 6'd24, 32'd0, 1'b1);
        runTxn("ld_f3_011", 1'b0, 3'b011, 32'h10, 32'd0, 6'd15, 6'd25, 32'd0, 1'b1);
        runTxn("lw_10_unchanged", 1'b0, 3'b010, 32'h10, 32'd0, 6'd16, 6'd26, 32'hDEAD77EF, 1'b0);

        // Backpressure on an aliased address: response must hold steady
        applyStimulus(1'b0, 3'b010, 32'h410, 32'd0, 6'd9, 6'd44);
        waitResp(n);
        checkOutput("bp_latency", 32'(n), 32'd2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_valid", {31'd0, resp_valid}, 32'd1);
            checkOutput("bp_req_ready", {31'd0, req_ready}, 32'd0);
            checkOutput("bp_value", resp_value, 32'hDEAD77EF);
            checkOutput("bp_rob", {26'd0, resp_rob_index}, 32'd9);
            checkOutput("bp_tag", {26'd0, resp_rd_tag}, 32'd44);
        end
        consumeResp();
        checkOutput("bp_valid_after", {31'd0, resp_valid}, 32'd0);
        checkOutput("bp_ready_after", {31'd0, req_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
